// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, address/data types and scanner states.
package regfile_pkg;

   localparam int RF_ADDR_W   = 6;
   localparam int RF_DATA_W   = 64;
   localparam int RF_NUM_REGS = 32;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } scan_state_t;

endpackage

// File: rtl/regfile_scanner.sv
// Register-file scanner: on start, reads every register through the read port
// and streams one valid/ready beat per register (address, data, last flag).
// Optional build macro REGFILE_SCANNER_SKIP_X0_EN: begin the scan at address 1
// so x0 is never read or emitted (needs NUM_REGS >= 2).
module regfile_scanner
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

`ifdef REGFILE_SCANNER_SKIP_X0_EN
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
`endif

   // Compare against the final address truncated to the index width.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   scan_state_t       state_reg;
   scan_state_t       state_next;
   logic [ADDR_W-1:0] idx_reg;
   logic [ADDR_W-1:0] out_addr_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_last_reg;

   // A beat is only held in SEND, so a transfer is SEND plus consumer ready.
   logic xfer;
   assign xfer = (state_reg == SEND) && out_ready;

   // State register; reset abandons any scan in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: READ and DONE last one cycle, SEND waits for a transfer.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: if (start) state_next = READ;
         READ: state_next = SEND;
         SEND: if (xfer) state_next = out_last_reg ? DONE : READ;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Index counter and beat capture; beat fields are frozen throughout SEND.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg      <= '0;
         out_addr_reg <= '0;
         out_data_reg <= '0;
         out_last_reg <= 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (start) idx_reg <= FIRST_IDX;
            end
            READ: begin
               out_data_reg <= rf_data;
               out_addr_reg <= idx_reg;
               out_last_reg <= (idx_reg == LAST_IDX);
            end
            SEND: begin
               // The index stops at the last address, so it never wraps.
               if (xfer && !out_last_reg) idx_reg <= idx_reg + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Status and handshake outputs decoded from the current state.
   always_comb begin
      busy      = (state_reg == READ) || (state_reg == SEND);
      done      = (state_reg == DONE);
      out_valid = (state_reg == SEND);
   end

   // rf_addr follows the index, so it holds its last value between scans.
   assign rf_addr  = idx_reg;
   assign out_addr = out_addr_reg;
   assign out_data = out_data_reg;
   assign out_last = out_last_reg;

endmodule
